// File: rtl/pcs_rx_pkg.sv
// pcs_rx_pkg: shared types and helpers for the 10GBASE-R receive path.
package pcs_rx_pkg;

  typedef enum logic [2:0] {
    LOCK_INIT,
    RESET_CNT,
    TEST_SH,
    SLIP,
    WAIT
  } lock_state_t;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // A sync header is legal only when its two bits differ.
  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_lock_rx_32b.sv
// block_lock_rx_32b: sync-header check and block-lock state machine for the
// 10GBASE-R RX path. Requests a bit slip from the aligner on header errors and
// registers the aligned word through to the descrambler.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// LOCK_INIT | drop lock, then start a fresh test window
// RESET_CNT | clear window counters; this cycle's header is not counted
// TEST_SH   | count headers and invalid headers, decide lock/slip at limits
// SLIP      | slip pulse is high for this single cycle, wait timer loaded
// WAIT      | aligner re-settling; headers ignored until the timer expires
module block_lock_rx_32b
  import pcs_rx_pkg::*;
#(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 66
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic [1:0]  ctrl_in,
  input  logic        din_en,
  input  logic        even_in,
  output logic [31:0] dout,
  output logic [1:0]  ctrl,
  output logic        dout_en,
  output logic        even,
  output logic        block_lock,
  output logic        slip,
  output logic [15:0] sh_err_cnt
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT - 1);

  lock_state_t       state_q;
  logic [CNT_W-1:0]  sh_cnt_q;
  logic [CNT_W-1:0]  sh_cnt_inc;
  logic [INV_W-1:0]  sh_inv_q;
  logic [INV_W-1:0]  sh_inv_inc;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [15:0]       sh_err_cnt_q;
  logic              block_lock_q;
  logic              block_lock_d;
  logic              slip_q;
  logic [31:0]       dout_q;
  logic [1:0]        ctrl_q;
  logic              dout_en_q;
  logic              even_q;

  logic hdr_ev;
  logic hdr_bad;
  logic test_ev;
  logic inv_hit;
  logic win_end;
  logic go_slip;

  // Header qualification and the lock/slip decision for the current header.
  always_comb begin
    hdr_ev     = din_en & even_in;
    hdr_bad    = hdr_ev & ~sh_is_valid(ctrl_in);
    test_ev    = hdr_ev & (state_q == TEST_SH);
    sh_cnt_inc = sh_cnt_q + CNT_W'(1);
    sh_inv_inc = sh_inv_q + INV_W'(hdr_bad);
    win_end    = (sh_cnt_inc == CNT_LAST);
    // Loss of lock is tested ahead of the window end so it wins a tie.
    inv_hit    = block_lock_q & (sh_inv_inc == INV_LAST);
    go_slip    = test_ev & (inv_hit | (~block_lock_q & hdr_bad));

    block_lock_d = block_lock_q;
    if (state_q == LOCK_INIT) begin
      block_lock_d = 1'b0;
    end else if (go_slip) begin
      block_lock_d = 1'b0;
    end else if (test_ev && win_end) begin
      block_lock_d = 1'b1;
    end
  end

  // Lock FSM with its window counters, slip pulse and error statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOCK_INIT;
      sh_cnt_q     <= '0;
      sh_inv_q     <= '0;
      wait_cnt_q   <= '0;
      sh_err_cnt_q <= '0;
      block_lock_q <= 1'b0;
      slip_q       <= 1'b0;
    end else begin
      block_lock_q <= block_lock_d;
      slip_q       <= go_slip;
      if (hdr_bad && (state_q != WAIT) && (sh_err_cnt_q != 16'hFFFF)) begin
        sh_err_cnt_q <= sh_err_cnt_q + 16'd1;
      end
      case (state_q)
        LOCK_INIT: state_q <= RESET_CNT;
        RESET_CNT: begin
          sh_cnt_q <= '0;
          sh_inv_q <= '0;
          state_q  <= TEST_SH;
        end
        TEST_SH: begin
          if (test_ev) begin
            sh_cnt_q <= sh_cnt_inc;
            sh_inv_q <= sh_inv_inc;
            if (go_slip) begin
              state_q <= SLIP;
            end else if (win_end) begin
              state_q <= RESET_CNT;
            end
          end
        end
        SLIP: begin
          wait_cnt_q <= WAIT_LOAD;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q <= RESET_CNT;
          end else begin
            wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
          end
        end
        default: state_q <= LOCK_INIT;
      endcase
    end
  end

  // One-cycle registered pass-through to the descrambler, gated by lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= '0;
      ctrl_q    <= '0;
      dout_en_q <= 1'b0;
      even_q    <= 1'b0;
    end else begin
      dout_q    <= din;
      ctrl_q    <= ctrl_in;
      dout_en_q <= din_en & block_lock_d;
      even_q    <= even_in;
    end
  end

  assign dout       = dout_q;
  assign ctrl       = ctrl_q;
  assign dout_en    = dout_en_q;
  assign even       = even_q;
  assign block_lock = block_lock_q;
  assign slip       = slip_q;
  assign sh_err_cnt = sh_err_cnt_q;

endmodule

// File: doc/block_lock_rx_32b.md
Name: block_lock_rx_32b

Overview:
Receive-side block-lock stage for the 10GBASE-R PCS, directly downstream of the 32-bit RX gearbox/aligner. Checks the 2-bit sync header once per 66-bit block and runs the IEEE 802.3 clause 49 lock state machine. Issues a one-cycle slip request back to the aligner on header errors. Forwards the data, header, enable and even phase, registered, to the descrambler.

Parameters:
SH_CNT_MAX, 64, headers per test window.
SH_INVALID_MAX, 16, invalid headers in one window that force loss of lock (locked state only).
SLIP_WAIT, 66, clk cycles to ignore headers after a slip while the aligner re-settles; minimum 1.

Ports:
clk  in  1  PCS RX clock
rst  in  1  synchronous active-high reset
din  in  32  aligned payload word from aligner
ctrl_in  in  2  sync header; meaningful only when din_en=1 and even_in=1
din_en  in  1  word valid from aligner
even_in  in  1  first (header-carrying) word of a 66-bit block
dout  out  32  din delayed 1 cycle
ctrl  out  2  ctrl_in delayed 1 cycle
dout_en  out  1  din_en delayed 1 cycle, forced 0 while block_lock=0
even  out  1  even_in delayed 1 cycle
block_lock  out  1  lock status
slip  out  1  one-cycle pulse; aligner shifts its bit alignment by one position
sh_err_cnt  out  16  saturating count of invalid headers since reset (diagnostic)

Behaviour:
- Reset: all outputs 0; state LOCK_INIT; all counters 0. rst is checked every cycle and overrides all other events, including mid-window and mid-wait.
- Header event: hdr_ev = din_en & even_in.
  - sh_valid = ctrl_in is 2'b01 or 2'b10.
  - 2'b00 and 2'b11 are invalid.
  - Headers are evaluated only on hdr_ev.
- Data path: 1-cycle latency for dout/ctrl/even. dout_en = registered (din_en & block_lock_next), so it tracks lock in the same cycle as dout.
- States:
  - LOCK_INIT: block_lock<=0; go to RESET_CNT.
  - RESET_CNT: sh_cnt<=0, sh_inv<=0; go to TEST_SH. The header of this cycle is not counted.
  - TEST_SH: on hdr_ev, sh_cnt+=1; if invalid, sh_inv+=1. After the increment:
    - unlocked, any invalid -> SLIP.
    - unlocked, sh_cnt==SH_CNT_MAX with no invalid -> block_lock<=1, RESET_CNT.
    - locked, sh_inv==SH_INVALID_MAX -> block_lock<=0, SLIP. Evaluated before the window-end check, so it wins if both occur on the same header.
    - locked, sh_cnt==SH_CNT_MAX with sh_inv<SH_INVALID_MAX -> RESET_CNT, lock held.
  - SLIP: slip=1 for exactly one cycle; wait counter <= SLIP_WAIT-1; go to WAIT.
  - WAIT: decrement each cycle and ignore headers; at 0 -> RESET_CNT.
- Widths: sh_cnt is clog2(SH_CNT_MAX+1) bits; sh_inv is clog2(SH_INVALID_MAX+1) bits. Neither can wrap, because the FSM leaves TEST_SH at the maximum.
- sh_err_cnt: increments on every invalid hdr_ev in any state except WAIT; saturates at 16'hFFFF.
- din_en=0 gaps (the aligner's skip cycle) do not advance counters.
- slip is never asserted on two consecutive cycles. Minimum spacing between slips is SLIP_WAIT+2 cycles.

Decomposition:
- Package pcs_rx_pkg holds:
  - lock_state_t enum {LOCK_INIT, RESET_CNT, TEST_SH, SLIP, WAIT};
  - SH_DATA=2'b01, SH_CTRL=2'b10;
  - function sh_is_valid.
- Single module; no sub-module needed. The counters stay inline with the FSM.

Test Plan:
- 64 consecutive valid headers (alternating 01/10) after reset -> block_lock rises 1 cycle after the 64th hdr_ev. dout_en is 0 before that and follows din_en after.
- Unlocked, header 2'b11 on the 10th block -> slip pulse 1 cycle later. No further slip and no counting for 66 cycles. Counting then restarts from 0.
- Locked, 15 invalid headers in one 64-block window -> lock held; the next window starts clean. 16 invalid in a window -> block_lock falls on the 16th with slip=1, sh_err_cnt=16.
- 16th invalid header landing on the 64th header of a window -> loss of lock wins: block_lock=0, slip=1.
- rst asserted during WAIT and during a locked window -> next cycle all outputs 0, state LOCK_INIT; relock requires a full 64 valid headers.
- din_en held low for 1 cycle in every 33 (aligner skip) -> counts advance only on din_en&even; lock still reached after exactly 64 blocks; sh_err_cnt saturates at FFFF under a continuous 2'b00 header stream.
